inst_encoder_issue: RTL
=======================

Name: inst_encoder_issue

Overview:
- Producer side of the 8-bit instruction interface consumed by inst_decoder.
- Accepts decoded-form instructions (one-hot instr_flag plus operand_a and operand_b) through a valid/ready handshake.
- Encodes each instruction into the 8-bit instruction word and buffers it in a small FIFO.
- Issues words downstream through a valid/ready handshake. Malformed requests are rejected and counted.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  request present.
- in_ready  output  1  request can be taken this cycle.
- instr_flag  input  5  one-hot opcode: [0]=MOV, [1]=ADD, [2]=SUB, [3]=CMP, [4]=NOP.
- operand_a  input  3  first register index.
- operand_b  input  3  second register index.
- out_valid  output  1  instruction word available.
- out_ready  input  1  consumer takes the word this cycle.
- out_inst  output  8  encoded instruction word.
- err  output  1  one-cycle pulse on a rejected request.
- err_count  output  CNT_W  saturating count of rejected requests.

Behaviour:
- Reset (async, rst=1): FIFO empties and pointers go to 0. Outputs: out_valid=0, out_inst=8'h00, err=0, err_count=0, in_ready=1 once the FIFO is empty.
- Encoding: out word = {op[1:0], operand_a, operand_b}.
  - Opcode values: MOV=2'b00, ADD=2'b01, SUB=2'b10, CMP=2'b11.
  - NOP always encodes as 8'h00; its operands are ignored.
- Validity: a request is valid only if instr_flag has exactly one bit set. Zero or multi-hot is invalid.
- Input handshake:
  - in_ready = !full. It is a registered-state function and does not depend on in_valid or out_ready.
  - A transfer happens when in_valid && in_ready.
  - Valid transfer: the encoded word is written at the tail.
  - Invalid transfer: the request is consumed with no write. err=1 on the following cycle only, and err_count increments, saturating at 2^CNT_W-1.
- Output handshake (first-word-fall-through):
  - out_valid = !empty and out_inst = head entry; out_inst=8'h00 while empty.
  - A pop happens on out_valid && out_ready.
  - out_inst/out_valid are held stable while out_valid && !out_ready.
- Latency: a word accepted at edge N is visible on out_inst/out_valid after edge N; there is no combinational bypass.
- Simultaneous push and pop:
  - Not full: both occur and occupancy is unchanged.
  - Full: in_ready=0, so only the pop occurs. in_ready rises the next cycle.
- Empty with out_ready=1: no pop and no pointer movement.
- Pointers wrap modulo DEPTH. Occupancy is tracked with a log2(DEPTH)+1 counter. Full means count==DEPTH; empty means count==0.
- Order: words leave strictly in acceptance order. Invalid requests leave no hole.
- Reset mid-operation: all buffered words are discarded immediately and asynchronously; no partial word is emitted.
- Back-to-back: one request per cycle is sustainable while not full. One issue per cycle is sustainable while not empty.

Optional Feature:
- Macro INST_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = even parity (XOR reduce) of out_inst, stored per entry.
  - out_parity is 0 when empty and at reset.
- Undefined: the port is absent and no parity storage exists. All other behaviour is identical.

Test Plan:
- After reset, push MOV a=1 b=0 with out_ready=1 -> out_inst=8'h08 one cycle later; with INST_PARITY_EN, out_parity=1.
- Push ADD a=3 b=5, SUB a=7 b=7, CMP a=0 b=1 on consecutive cycles with out_ready=1 -> 8'h5D, 8'hBF, 8'hC1 in order on consecutive cycles.
- Push NOP with a=6 b=2 -> out_inst=8'h00 with out_valid=1.
- Push flag 5'b00011, then flag 5'b00000 -> two err pulses, err_count=2, out_valid stays 0. A following valid ADD a=1 b=1 emits 8'h49.
- Hold out_ready=0 and push 5 valid requests -> first 4 accepted, in_ready=0 on the 5th. Raise out_ready for one cycle -> head pops and in_ready=1 next cycle; the 5th is then accepted and order is preserved.
- Fill with 3 words, assert rst mid-cycle -> out_valid=0 and out_inst=8'h00 immediately. After release, the next push emits only the new word.

Source files
------------

// File: rtl/inst_encoder_issue.sv
// Instruction encoder/issuer: encodes one-hot decoded requests into 8-bit words and buffers them in a FWFT FIFO.
// Optional INST_PARITY_EN adds a per-entry even-parity bit on out_parity.
module inst_encoder_issue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       instr_flag,
  input  logic [2:0]       operand_a,
  input  logic [2:0]       operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_inst,
  output logic             err,
`ifdef INST_PARITY_EN
  output logic             out_parity,
`endif
  output logic [CNT_W-1:0] err_count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          flag_ok;
  logic          accept;
  logic          push;
  logic          pop;
  logic [7:0]    word;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign flag_ok = (instr_flag != 5'd0) && ((instr_flag & (instr_flag - 5'd1)) == 5'd0);

  always_comb begin
    word = 8'h00;
    case (instr_flag)
      5'b00001: word = {2'b00, operand_a, operand_b};
      5'b00010: word = {2'b01, operand_a, operand_b};
      5'b00100: word = {2'b10, operand_a, operand_b};
      5'b01000: word = {2'b11, operand_a, operand_b};
      default:  word = 8'h00;
    endcase
  end

  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && flag_ok;
  assign pop      = !empty && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage holds no reset: emptiness is governed solely by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  assign out_valid = !empty;
  assign out_inst  = empty ? 8'h00 : mem[rd_ptr];

`ifdef INST_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push) par_mem[wr_ptr] <= ^word;
  end

  assign out_parity = empty ? 1'b0 : par_mem[rd_ptr];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= accept && !flag_ok;
      if (accept && !flag_ok && (err_count != '1))
        err_count <= err_count + 1'b1;
    end
  end

endmodule
